// File: rtl/mul_div_seq_pkg.sv
// Shared constants and types for the 8051 MUL AB / DIV AB sequencer.
// SFR addresses mirror the shared opcode defines so the unit can stand alone.
package mul_div_seq_pkg;
    localparam logic [7:0] SFR_ACC = 8'hE0;
    localparam logic [7:0] SFR_B   = 8'hF0;

    localparam logic MD_MUL = 1'b0;
    localparam logic MD_DIV = 1'b1;

    localparam logic [2:0] LAST_STEP = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_WR_A,
        S_WR_B,
        S_DONE
    } md_state_e;
endpackage

// File: rtl/mul_div_core.sv
// Iterative 8x8 datapath: one shift-add (MUL) or restoring shift-subtract (DIV)
// step per cycle. {hi,lo} holds product for MUL, {remainder,quotient} for DIV.
module mul_div_core
    import mul_div_seq_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic       step,
    input  logic       op,
    input  logic [7:0] a_in,
    input  logic [7:0] b_in,
    output logic [7:0] lo,
    output logic [7:0] hi
);
    logic [7:0] lo_q, lo_d;
    logic [7:0] hi_q, hi_d;
    logic [7:0] b_q,  b_d;
    logic [8:0] sum;
    logic [8:0] rem9;

    always_comb begin
        lo_d = lo_q;
        hi_d = hi_q;
        b_d  = b_q;
        sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : 9'd0);
        rem9 = {hi_q, lo_q[7]};
        if (load) begin
            lo_d = a_in;
            hi_d = 8'd0;
            b_d  = b_in;
        end else if (step) begin
            if (op == MD_MUL) begin
                // Multiplier bits retire out of lo as product bits shift in.
                hi_d = sum[8:1];
                lo_d = {sum[0], lo_q[7:1]};
            end else if (rem9 >= {1'b0, b_q}) begin
                hi_d = 8'(rem9 - {1'b0, b_q});
                lo_d = {lo_q[6:0], 1'b1};
            end else begin
                hi_d = rem9[7:0];
                lo_d = {lo_q[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lo_q <= 8'd0;
            hi_q <= 8'd0;
            b_q  <= 8'd0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
            b_q  <= b_d;
        end
    end

    assign lo = lo_q;
    assign hi = hi_q;
endmodule

// File: rtl/mul_div_seq.sv
// MUL AB / DIV AB sequencer: runs the core for 8 steps, writes ACC then B over
// the shared SFR bus, and otherwise passes the CPU's SFR writes straight through.
module mul_div_seq
    import mul_div_seq_pkg::*;
#(
    parameter logic [7:0] ADDR_ACC = SFR_ACC,
    parameter logic [7:0] ADDR_B   = SFR_B
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       op,
    input  logic [7:0] acc_in,
    input  logic [7:0] b_in,
    output logic       busy,
    output logic       done,
    output logic       ov,
    output logic       cy,
    input  logic       cpu_wr_en,
    input  logic       cpu_wr_bit_en,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_data,
    input  logic       cpu_bit_in,
    output logic       cpu_wr_gnt,
    output logic       sfr_wr_en,
    output logic       sfr_wr_bit_en,
    output logic [7:0] sfr_addr,
    output logic [7:0] sfr_data,
    output logic       sfr_bit_in
);
    md_state_e  state_q;
    logic [2:0] cnt_q;
    logic       op_q;
    logic       busy_q, done_q, ov_q, cy_q;
    logic [7:0] res_lo, res_hi;
    logic       load, unit_own;

    assign load = (state_q == S_IDLE) && start;

    mul_div_core u_core (
        .clock (clock),
        .reset (reset),
        .load  (load),
        .step  (state_q == S_CALC),
        .op    (op_q),
        .a_in  (acc_in),
        .b_in  (b_in),
        .lo    (res_lo),
        .hi    (res_hi)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            op_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ov_q    <= 1'b0;
            cy_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (start) begin
                    op_q   <= op;
                    ov_q   <= 1'b0;
                    cy_q   <= 1'b0;
                    busy_q <= 1'b1;
                    // Divide-by-zero skips the datapath and leaves ACC/B untouched.
                    if (op == MD_DIV && b_in == 8'd0) begin
                        state_q <= S_DONE;
                        ov_q    <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_CALC;
                        cnt_q   <= LAST_STEP;
                    end
                end
                S_CALC: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd0) state_q <= S_WR_A;
                end
                S_WR_A: state_q <= S_WR_B;
                S_WR_B: begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                    ov_q    <= (op_q == MD_MUL) && (res_hi != 8'd0);
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign ov   = ov_q;
    assign cy   = cy_q;

    assign unit_own      = (state_q == S_WR_A) || (state_q == S_WR_B);
    assign cpu_wr_gnt    = !unit_own;
    assign sfr_wr_en     = unit_own ? 1'b1 : cpu_wr_en;
    assign sfr_wr_bit_en = unit_own ? 1'b0 : cpu_wr_bit_en;
    assign sfr_bit_in    = unit_own ? 1'b0 : cpu_bit_in;
    assign sfr_addr      = !unit_own ? cpu_addr :
                           (state_q == S_WR_A) ? ADDR_ACC : ADDR_B;
    assign sfr_data      = !unit_own ? cpu_data :
                           (state_q == S_WR_A) ? res_lo : res_hi;
endmodule

// File: tb/tb_mul_div_seq.sv
// Bench for mul_div_seq: directed vector table, hand-built corner sequences and
// random ops checked against plain-arithmetic MUL/DIV results.
module tb_mul_div_seq;
    logic       clock = 1'b0;
    logic       reset, start, op;
    logic [7:0] acc_in, b_in;
    logic       busy, done, ov, cy;
    logic       cpu_wr_en, cpu_wr_bit_en, cpu_bit_in;
    logic [7:0] cpu_addr, cpu_data;
    logic       cpu_wr_gnt;
    logic       sfr_wr_en, sfr_wr_bit_en, sfr_bit_in;
    logic [7:0] sfr_addr, sfr_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    mul_div_seq dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .acc_in(acc_in), .b_in(b_in),
        .busy(busy), .done(done), .ov(ov), .cy(cy),
        .cpu_wr_en(cpu_wr_en), .cpu_wr_bit_en(cpu_wr_bit_en),
        .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_bit_in(cpu_bit_in),
        .cpu_wr_gnt(cpu_wr_gnt),
        .sfr_wr_en(sfr_wr_en), .sfr_wr_bit_en(sfr_wr_bit_en),
        .sfr_addr(sfr_addr), .sfr_data(sfr_data), .sfr_bit_in(sfr_bit_in)
    );

    typedef struct {
        logic       op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        logic       exp_ov;
    } vec_t;

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    // Reference: 8051 semantics in plain arithmetic.
    task automatic model(input logic o, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] ea, output logic [7:0] eb, output logic eov);
        int p;
        if (o == 1'b0) begin
            p   = int'(a) * int'(b);
            ea  = 8'(p % 256);
            eb  = 8'(p / 256);
            eov = (p > 255);
        end else if (b == 8'd0) begin
            ea = a; eb = b; eov = 1'b1;
        end else begin
            ea  = 8'(int'(a) / int'(b));
            eb  = 8'(int'(a) % int'(b));
            eov = 1'b0;
        end
    endtask

    task automatic run_op(input logic o, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ea, input logic [7:0] eb, input logic eov,
                          input logic hold_cpu, input logic spur, input string tag);
        int nwr = 0, done_n = 0, done_at = -1, busy_n = 0, gnt0 = 0, bad_pass = 0;
        int a_at = -1, b_at = -1;
        logic [7:0] got_a = 8'h00, got_b = 8'h00;
        logic div0;
        div0 = (o == 1'b1) && (b == 8'd0);
        @(negedge clock);
        start = 1'b1; op = o; acc_in = a; b_in = b;
        if (hold_cpu) begin
            cpu_wr_en = 1'b1; cpu_wr_bit_en = 1'b0; cpu_addr = 8'hF0; cpu_data = 8'h55;
        end
        @(posedge clock);
        #1 start = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            if (busy) busy_n++;
            if (done) begin done_n++; done_at = k; end
            if (!cpu_wr_gnt) gnt0++;
            if (sfr_wr_en && !cpu_wr_gnt) begin
                nwr++;
                if (sfr_addr == 8'hE0) begin got_a = sfr_data; a_at = k; end
                else if (sfr_addr == 8'hF0) begin got_b = sfr_data; b_at = k; end
            end
            if (hold_cpu && cpu_wr_gnt &&
                !(sfr_wr_en && !sfr_wr_bit_en && sfr_addr == 8'hF0 && sfr_data == 8'h55))
                bad_pass++;
            start = spur && (k == 3);
        end
        start = 1'b0; cpu_wr_en = 1'b0;
        chk({tag, " unit writes"}, nwr, div0 ? 0 : 2);
        chk({tag, " gnt low cycles"}, gnt0, div0 ? 0 : 2);
        chk({tag, " done edge"}, done_at, div0 ? 1 : 11);
        chk({tag, " done count"}, done_n, 1);
        chk({tag, " busy cycles"}, busy_n, div0 ? 1 : 11);
        if (!div0) begin
            chk({tag, " ACC write edge"}, a_at, 9);
            chk({tag, " ACC data"}, int'(got_a), int'(ea));
            chk({tag, " B write edge"}, b_at, 10);
            chk({tag, " B data"}, int'(got_b), int'(eb));
        end
        chk({tag, " ov"}, int'(ov), int'(eov));
        chk({tag, " cy"}, int'(cy), 0);
        chk({tag, " busy after"}, int'(busy), 0);
        if (hold_cpu) chk({tag, " cpu passthrough"}, bad_pass, 0);
    endtask

    initial begin
        vec_t vt[5];
        logic [7:0] ea, eb, ra, rb;
        logic eov, ro;
        int wr_seen, done_seen;

        vt[0] = '{1'b0, 8'h0C, 8'h0A, 8'h78, 8'h00, 1'b0};
        vt[1] = '{1'b0, 8'h50, 8'hA0, 8'h00, 8'h32, 1'b1};
        vt[2] = '{1'b1, 8'hFB, 8'h12, 8'h0D, 8'h11, 1'b0};
        vt[3] = '{1'b1, 8'h07, 8'hFF, 8'h00, 8'h07, 1'b0};
        vt[4] = '{1'b1, 8'h3C, 8'h00, 8'h3C, 8'h00, 1'b1};

        reset = 1'b1; start = 1'b0; op = 1'b0; acc_in = 8'h00; b_in = 8'h00;
        cpu_wr_en = 1'b0; cpu_wr_bit_en = 1'b0; cpu_addr = 8'h00; cpu_data = 8'h00; cpu_bit_in = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("reset busy/done/ov/cy", int'({busy, done, ov, cy}), 0);
        chk("reset gnt", int'(cpu_wr_gnt), 1);
        cpu_wr_en = 1'b1; cpu_wr_bit_en = 1'b1; cpu_addr = 8'hD7; cpu_data = 8'hA5; cpu_bit_in = 1'b1;
        #1;
        chk("idle passthrough", int'({sfr_wr_en, sfr_wr_bit_en, sfr_addr, sfr_data, sfr_bit_in}),
            int'({1'b1, 1'b1, 8'hD7, 8'hA5, 1'b1}));
        cpu_wr_en = 1'b0; cpu_wr_bit_en = 1'b0; cpu_bit_in = 1'b0;

        foreach (vt[i]) begin
            run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].exp_a, vt[i].exp_b, vt[i].exp_ov,
                   1'b0, 1'b0, $sformatf("vec%0d", i));
        end
        repeat (5) @(negedge clock);
        chk("ov held while idle", int'(ov), 1);

        // CPU write held across WR_A/WR_B plus an ignored start during CALC.
        run_op(1'b0, 8'h0C, 8'h0A, 8'h78, 8'h00, 1'b0, 1'b1, 1'b1, "arb");

        // Reset mid-CALC discards the result.
        @(negedge clock);
        start = 1'b1; op = 1'b0; acc_in = 8'h9A; b_in = 8'hC3;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mid reset busy", int'(busy), 0);
        chk("mid reset ov", int'(ov), 0);
        wr_seen = 0; done_seen = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clock);
            if (sfr_wr_en || !cpu_wr_gnt) wr_seen++;
            if (done) done_seen++;
        end
        chk("mid reset no writes", wr_seen, 0);
        chk("mid reset no done", done_seen, 0);
        run_op(1'b0, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1, 1'b0, 1'b0, "ffxff");

        for (int i = 0; i < 40; i++) begin
            ro = 1'(($urandom % 2));
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            model(ro, ra, rb, ea, eb, eov);
            run_op(ro, ra, rb, ea, eb, eov, 1'($urandom % 2), 1'b0, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
